// File: rtl/ic_bvsge_udiv_witness_seq_pkg.sv
// Shared types and helpers for the (x udiv s) >=s t witness generator.
package ic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Largest signed value representable in w bits (0111..1).
    function automatic logic [31:0] max_s(input int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    function automatic logic sge(input logic signed [31:0] a, input logic signed [31:0] b);
        return a >= b;
    endfunction

endpackage

// File: rtl/ic_bvsge_udiv_witness_seq_udiv.sv
// Bit-serial restoring unsigned divider, one quotient bit per cycle, MSB first.
// Division by zero yields an all-ones quotient.
module udiv_restoring_serial #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [W-1:0] i_dividend,
    input  logic [W-1:0] i_divisor,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_quotient
);
    localparam int unsigned CW = $clog2(W);

    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_rem;
    logic [W-1:0]  r_dvd;
    logic [W-1:0]  r_dvs;
    logic [W-1:0]  r_q;
    logic          r_busy;
    logic          r_done;
    logic          r_zero;
    logic [W:0]    w_shift;
    logic [W:0]    w_diff;

    // Extra top bit of w_diff is the borrow: set when the shifted remainder is below the divisor.
    always_comb begin
        w_shift = {r_rem, r_dvd[r_cnt]};
        w_diff  = w_shift - {1'b0, r_dvs};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_rem  <= '0;
            r_dvd  <= '0;
            r_dvs  <= '0;
            r_q    <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_zero <= 1'b0;
        end else if (i_start) begin
            r_cnt  <= CW'(W - 1);
            r_rem  <= '0;
            r_dvd  <= i_dividend;
            r_dvs  <= i_divisor;
            r_q    <= '0;
            r_busy <= 1'b1;
            r_done <= 1'b0;
            r_zero <= (i_divisor == '0);
        end else if (r_busy) begin
            if (!w_diff[W]) begin
                r_rem        <= w_diff[W-1:0];
                r_q[r_cnt]   <= 1'b1;
            end else begin
                r_rem <= w_shift[W-1:0];
            end
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_quotient = r_zero ? '1 : r_q;

endmodule

// File: rtl/ic_bvsge_udiv_witness_seq.sv
// Sequential Skolem witness generator for (x udiv s) >=s t: picks the quotient-maximising x,
// divides it by s on a serial divider and reports satisfiability with the checked quotient.
module ic_bvsge_udiv_witness_seq
    import ic_pkg::*;
#(
    parameter int unsigned W       = 4,
    parameter bit          LAT_FIX = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_s,
    input  logic [W-1:0] in_t,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_sat,
    output logic [W-1:0] out_x,
    output logic [W-1:0] out_q
);
    localparam logic [W-1:0] MAX_S = W'(max_s(W));

    state_t       r_state;
    state_t       w_next;
    logic [W-1:0] r_s;
    logic [W-1:0] r_t;
    logic [W-1:0] r_x;
    logic         r_short;
    logic         r_out_sat;
    logic [W-1:0] r_out_x;
    logic [W-1:0] r_out_q;

    logic         w_accept;
    logic [W-1:0] w_x_in;
    logic         w_short_in;
    logic         w_div_rst;
    logic         w_div_busy;
    logic         w_div_done;
    logic [W-1:0] w_div_q;
    logic [W-1:0] w_q_res;

    assign w_accept   = in_valid && in_ready;
    assign w_x_in     = (in_s == W'(1)) ? MAX_S : '1;
    assign w_short_in = !LAT_FIX && (in_s <= W'(1));
    // Divider is held cleared while idle so no stale state lingers between requests.
    assign w_div_rst  = rst || ((r_state == IDLE) && !w_accept);
    assign w_q_res    = r_short ? ((r_s == '0) ? '1 : MAX_S) : w_div_q;

    udiv_restoring_serial #(.W(W)) u_div (
        .clk        (clk),
        .rst        (w_div_rst),
        .i_start    (w_accept && !w_short_in),
        .i_dividend (w_x_in),
        .i_divisor  (in_s),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quotient (w_div_q)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (w_accept) w_next = DIV;
            DIV:  if (r_short || (w_div_done && !w_div_busy)) w_next = CMP;
            CMP:  w_next = DONE;
            DONE: if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
        out_sat   = r_out_sat;
        out_x     = r_out_x;
        out_q     = r_out_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s       <= '0;
            r_t       <= '0;
            r_x       <= '0;
            r_short   <= 1'b0;
            r_out_sat <= 1'b0;
            r_out_x   <= '0;
            r_out_q   <= '0;
        end else begin
            if (w_accept) begin
                r_s     <= in_s;
                r_t     <= in_t;
                r_x     <= w_x_in;
                r_short <= w_short_in;
            end
            if (r_state == CMP) begin
                r_out_x   <= r_x;
                r_out_q   <= w_q_res;
                r_out_sat <= sge(32'($signed(w_q_res)), 32'($signed(r_t)));
            end
        end
    end

endmodule

// File: tb/tb_ic_bvsge_udiv_witness_seq.sv
// Randomised and directed bench for ic_bvsge_udiv_witness_seq against a brute-force reference.
module tb_ic_bvsge_udiv_witness_seq;
    localparam int W   = 4;
    localparam int ALL = (1 << W) - 1;
    localparam int MXS = (1 << (W - 1)) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid  [2];
    logic         in_ready  [2];
    logic [W-1:0] in_s      [2];
    logic [W-1:0] in_t      [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic         out_sat   [2];
    logic [W-1:0] out_x     [2];
    logic [W-1:0] out_q     [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ic_bvsge_udiv_witness_seq #(.W(W), .LAT_FIX(1'b1)) u_fix (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_s(in_s[0]), .in_t(in_t[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_sat(out_sat[0]),
        .out_x(out_x[0]), .out_q(out_q[0])
    );

    ic_bvsge_udiv_witness_seq #(.W(W), .LAT_FIX(1'b0)) u_var (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_s(in_s[1]), .in_t(in_t[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_sat(out_sat[1]),
        .out_x(out_x[1]), .out_q(out_q[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int to_signed(input int v);
        return (v > MXS) ? v - (ALL + 1) : v;
    endfunction

    // Witness from the maximising rule; sat decided by trying every x.
    function automatic void ref_model(input int s, input int t, output int x, output int q, output int sat);
        int qq;
        x   = (s == 1) ? MXS : ALL;
        q   = (s == 0) ? ALL : x / s;
        sat = 0;
        for (int xx = 0; xx <= ALL; xx++) begin
            qq = (s == 0) ? ALL : xx / s;
            if (to_signed(qq) >= to_signed(t)) sat = 1;
        end
    endfunction

    task automatic run_txn(input int d, input int s, input int t, input int stall, input int exp_lat);
        int    rx, rq, rs, lat;
        string tag;
        ref_model(s, t, rx, rq, rs);
        tag = $sformatf("d%0d s=%0h t=%0h", d, s, t);
        @(negedge clk);
        check({tag, " in_ready_idle"}, 32'(in_ready[d]), 1);
        in_valid[d] = 1'b1;
        in_s[d]     = W'(s);
        in_t[d]     = W'(t);
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        in_s[d]     = W'($urandom);
        in_t[d]     = W'($urandom);
        lat = 0;
        while (!out_valid[d] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " x"}, 32'(out_x[d]), 32'(rx));
        check({tag, " q"}, 32'(out_q[d]), 32'(rq));
        check({tag, " sat"}, 32'(out_sat[d]), 32'(rs));
        check({tag, " in_ready_busy"}, 32'(in_ready[d]), 0);
        repeat (stall) begin
            @(posedge clk);
            #1;
            check({tag, " held_valid"}, 32'(out_valid[d]), 1);
        end
        @(negedge clk);
        out_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[d] = 1'b0;
        check({tag, " valid_drop"}, 32'(out_valid[d]), 0);
        check({tag, " ready_back"}, 32'(in_ready[d]), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ds [8];
        int dt [8];
        int bs, bt;
        logic [W-1:0] hx, hq;
        logic         hsat;

        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            in_s[d]      = '0;
            in_t[d]      = '0;
            out_ready[d] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d reset in_ready", d), 32'(in_ready[d]), 1);
            check($sformatf("d%0d reset out_valid", d), 32'(out_valid[d]), 0);
            check($sformatf("d%0d reset sat", d), 32'(out_sat[d]), 0);
            check($sformatf("d%0d reset x", d), 32'(out_x[d]), 0);
            check($sformatf("d%0d reset q", d), 32'(out_q[d]), 0);
        end

        ds = '{0, 0, 1, 1, 3, 3, 15, 8};
        dt = '{15, 0, 7, 8, 5, 6, 1, 2};
        for (int i = 0; i < 8; i++) run_txn(0, ds[i], dt[i], 0, W + 2);

        for (int i = 0; i < 40; i++)
            run_txn(0, int'($urandom_range(ALL)), int'($urandom_range(ALL)),
                    int'($urandom_range(3)), W + 2);

        // Backpressure with a competing request that must be ignored.
        @(negedge clk);
        in_valid[0] = 1'b1; in_s[0] = 4'd3; in_t[0] = 4'd5;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        bs = 0;
        while (!out_valid[0] && bs < 40) begin @(posedge clk); #1; bs++; end
        check("bp latency", 32'(bs), W + 2);
        hx = out_x[0]; hq = out_q[0]; hsat = out_sat[0];
        check("bp x", 32'(hx), 15);
        check("bp q", 32'(hq), 5);
        check("bp sat", 32'(hsat), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid[0] = 1'b1; in_s[0] = 4'd8; in_t[0] = 4'd7;
            @(posedge clk);
            #1;
            check("bp hold valid", 32'(out_valid[0]), 1);
            check("bp in_ready low", 32'(in_ready[0]), 0);
            check("bp hold x", 32'(out_x[0]), 15);
            check("bp hold q", 32'(out_q[0]), 5);
            check("bp hold sat", 32'(out_sat[0]), 1);
        end
        @(negedge clk);
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        check("bp valid drop", 32'(out_valid[0]), 0);
        check("bp ready back", 32'(in_ready[0]), 1);
        run_txn(0, 8, 2, 0, W + 2);

        // Reset during the third divide cycle.
        @(negedge clk);
        in_valid[0] = 1'b1; in_s[0] = 4'd15; in_t[0] = 4'd1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst in_ready", 32'(in_ready[0]), 1);
        check("rst out_valid", 32'(out_valid[0]), 0);
        check("rst sat", 32'(out_sat[0]), 0);
        check("rst x", 32'(out_x[0]), 0);
        check("rst q", 32'(out_q[0]), 0);
        run_txn(0, 3, 6, 1, W + 2);

        // Shortcut latency and full sweep on the variable-latency instance.
        for (int s = 0; s <= ALL; s++)
            for (int t = 0; t <= ALL; t++)
                run_txn(1, s, t, 0, (s <= 1) ? 2 : W + 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
